// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared fixed-point widths, range limits and rounding constant
package fxp_pkg;

    function automatic int acc_width(input int n, input int g);
        return 2 * n + g;
    endfunction

    // Returned as 64-bit patterns; callers take the low n bits.
    function automatic logic [63:0] fxp_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fxp_min(input int n);
        return ~64'd0 << (n - 1);
    endfunction

    function automatic logic [63:0] rnd_half(input int q);
        return 64'd1 << (q - 1);
    endfunction

endpackage

// File: rtl/fxp_mac_stream_if.sv
// rtl/fxp_mac_stream_if.sv - operand beat stream, clock enable and result bundle
interface fxp_mac_stream_if #(
    parameter int N = 16
);
    logic         ce;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         in_valid;
    logic         in_last;
    logic [N-1:0] p;
    logic         out_valid;
    logic         ovf;

    modport master (
        output ce, a, b, in_valid, in_last,
        input  p, out_valid, ovf
    );

    modport slave (
        input  ce, a, b, in_valid, in_last,
        output p, out_valid, ovf
    );
endinterface

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - round-half-up to Q bits, range check, clamp when FXP_MAC_SAT_EN
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int ACC_W = 36
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [N-1:0]     res,
    output logic                    ovf
);
    localparam int RW = ACC_W + 1 - Q;

    // One extra bit so adding the half-LSB can never wrap the sum.
    logic signed [ACC_W:0] rnd;
    logic        [RW-1:0]  r;
    logic        [RW-N:0]  upper;

    assign rnd   = {sum[ACC_W-1], sum} + (ACC_W + 1)'(rnd_half(Q));
    assign r     = rnd[ACC_W:Q];
    assign upper = r[RW-1:N-1];
    assign ovf   = ~((&upper) | ~(|upper));

`ifdef FXP_MAC_SAT_EN
    always_comb begin
        res = r[N-1:0];
        if (ovf) begin
            res = r[RW-1] ? N'(fxp_min(N)) : N'(fxp_max(N));
        end
    end
`else
    assign res = r[N-1:0];
`endif

endmodule

// File: rtl/fxp_mac_stream.sv
// rtl/fxp_mac_stream.sv - streaming signed Q-format dot product; FXP_MAC_SAT_EN selects clamping
module fxp_mac_stream
    import fxp_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 12,
    parameter int G = 4
) (
    input  logic             clk,
    input  logic             rst,
    fxp_mac_stream_if.slave  s
);
    localparam int ACC_W = acc_width(N, G);

    logic signed [2*N-1:0]  prod_r;
    logic                   v1;
    logic                   l1;
    logic signed [ACC_W-1:0] acc;
    logic                   first;
    logic        [N-1:0]    p_r;
    logic                   ovf_r;
    logic                   ov_r;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic        [N-1:0]    res;
    logic                   res_ovf;

    assign prod_ext = {{G{prod_r[2*N-1]}}, prod_r};
    assign base     = first ? '0 : acc;
    assign sum      = base + prod_ext;

    fxp_round_sat #(
        .N     (N),
        .Q     (Q),
        .ACC_W (ACC_W)
    ) u_round_sat (
        .sum (sum),
        .res (res),
        .ovf (res_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r <= '0;
            v1     <= 1'b0;
            l1     <= 1'b0;
            acc    <= '0;
            first  <= 1'b1;
            p_r    <= '0;
            ovf_r  <= 1'b0;
            ov_r   <= 1'b0;
        end else if (s.ce) begin
            prod_r <= $signed(s.a) * $signed(s.b);
            v1     <= s.in_valid;
            l1     <= s.in_last;
            ov_r   <= 1'b0;
            if (v1) begin
                acc   <= sum;
                first <= l1;
                if (l1) begin
                    p_r   <= res;
                    ovf_r <= res_ovf;
                    ov_r  <= 1'b1;
                end
            end
        end
    end

    // A pending pulse is held through a stall and shown once ce returns.
    assign s.out_valid = ov_r & s.ce;
    assign s.p         = p_r;
    assign s.ovf       = ovf_r;

endmodule

// File: tb/tb_fxp_mac_stream.sv
// tb/tb_fxp_mac_stream.sv - directed vectors with hand-computed results for fxp_mac_stream
module tb_fxp_mac_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   bad_ce = 0;
    logic [16:0] res_q[$];

    always #5 clk = ~clk;

    fxp_mac_stream_if #(.N(16)) bus ();

    fxp_mac_stream #(.N(16), .Q(12), .G(4)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    always @(negedge clk) begin
        if (bus.out_valid) begin
            res_q.push_back({bus.ovf, bus.p});
            if (!bus.ce) bad_ce++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        bus.in_last = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_one(input string tag, input logic [15:0] exp_p, input logic exp_ovf);
        idle(4);
        check({tag, "_pulses"}, res_q.size(), 1);
        if (res_q.size() >= 1) begin
            check({tag, "_p"}, res_q[0][15:0], exp_p);
            check({tag, "_ovf"}, res_q[0][16], exp_ovf);
        end
        res_q.delete();
    endtask

    initial begin
        logic [15:0] sat_pos;
        logic [15:0] sat_neg;
`ifdef FXP_MAC_SAT_EN
        sat_pos = 16'h7FFF;
        sat_neg = 16'h8000;
`else
        sat_pos = 16'h0000;
        sat_neg = 16'h0000;
`endif
        bus.ce = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_p", bus.p, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_ovf", bus.ovf, 0);
        rst = 1'b0;
        idle(1);

        // single beat with latency check
        beat(16'h1800, 16'h2000, 1'b1);
        check("lat_edge1_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2_valid", bus.out_valid, 1);
        check("lat_edge2_p", bus.p, 16'h3000);
        expect_one("single", 16'h3000, 1'b0);

        // two 3-beat vectors back to back
        for (int v = 0; v < 2; v++) begin
            beat(16'h1000, 16'h1000, 1'b0);
            beat(16'h2000, 16'h1000, 1'b0);
            beat(16'h0800, 16'h2000, 1'b1);
        end
        idle(4);
        check("b2b_pulses", res_q.size(), 2);
        for (int i = 0; i < 2 && i < res_q.size(); i++) begin
            check("b2b_p", res_q[i][15:0], 16'h4000);
            check("b2b_ovf", res_q[i][16], 0);
        end
        res_q.delete();

        // positive overflow
        for (int i = 0; i < 4; i++) beat(16'h4000, 16'h4000, i == 3);
        expect_one("sat_pos", sat_pos, 1'b1);

        // negative overflow
        beat(16'hC000, 16'h4000, 1'b1);
        expect_one("sat_neg", sat_neg, 1'b1);

        // exactly -8.0 is representable
        beat(16'hC000, 16'h2000, 1'b1);
        expect_one("min_exact", 16'h8000, 1'b0);

        // rounding: half LSB rounds up, just below rounds down, negative half goes to zero
        beat(16'h0001, 16'h0800, 1'b1);
        expect_one("rnd_half", 16'h0001, 1'b0);
        beat(16'h0001, 16'h07FF, 1'b1);
        expect_one("rnd_below", 16'h0000, 1'b0);
        beat(16'hFFFF, 16'h0800, 1'b1);
        expect_one("rnd_neg_half", 16'h0000, 1'b0);

        // stall and bubble mid-vector; junk on inputs while ce=0
        beat(16'h1000, 16'h1000, 1'b0);
        bus.ce = 1'b0;
        bus.a = 16'h7777;
        bus.b = 16'h7777;
        bus.in_valid = 1'b1;
        bus.in_last = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.ce = 1'b1;
        idle(1);
        beat(16'h1000, 16'h1000, 1'b1);
        expect_one("stall", 16'h2000, 1'b0);

        // stall while the result is pending: pulse appears once after ce returns
        beat(16'h1000, 16'h2000, 1'b1);
        bus.ce = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.ce = 1'b1;
        expect_one("stall_pending", 16'h2000, 1'b0);
        check("no_valid_while_ce0", bad_ce, 0);

        // reset mid-vector discards partial sum
        beat(16'h1000, 16'h1000, 1'b0);
        beat(16'h1000, 16'h1000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_p", bus.p, 0);
        check("rst_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(16'h1000, 16'h1000, 1'b1);
        expect_one("after_rst", 16'h1000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
